vreg_bank: RTL and testbench
============================

Name: vreg_bank

Overview:
- Parametrised successor to the single 16-bit enable register: a bank of DEPTH vector registers, each WIDTH bits.
- One lane-masked write port, two registered read ports with write-to-read bypass, and a sequenced clear-all engine.
- Sits between the memory-to-memory datapath and the ALU. Holds operand/result vectors between memory transfers.

Parameters:
- WIDTH, 16: bits per register; must be a multiple of LANES.
- DEPTH, 8: number of registers; power of two, at least 2.
- LANES, 2: write-mask granularity; lane width LW = WIDTH/LANES.
- Derived localparam AW = clog2(DEPTH), the address width.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  write request.
- waddr  input  AW  write register index.
- wdata  input  WIDTH  write data.
- wmask  input  LANES  per-lane write enable; bit i covers wdata[i*LW +: LW].
- wr_ready  output  1  write accepted this cycle; equals !clr_busy.
- raddr_a  input  AW  read port A index.
- rdata_a  output  WIDTH  read port A data, registered.
- raddr_b  input  AW  read port B index.
- rdata_b  output  WIDTH  read port B data, registered.
- clr_req  input  1  start clear-all.
- clr_busy  output  1  clear sequencer active.
- clr_done  output  1  one-cycle pulse when clear completes.
- par_flip  input  1  test hook: invert stored parity of lanes written this cycle (PARITY_EN only).
- par_err_a  output  1  parity error on rdata_a, registered with rdata_a.
- par_err_b  output  1  parity error on rdata_b, registered with rdata_b.

Behaviour:
- Reset (rst=0, asynchronous): all registers, rdata_a, rdata_b, par_err_* cleared to 0. clr_busy=0, clr_done=0, sequencer IDLE, clear counter=0. Reset mid-clear aborts the clear with no clr_done.
- Write: on a clk edge with we=1 and wr_ready=1, lanes with wmask[i]=1 take wdata; other lanes hold. we with wmask=0 is a no-op.
- Write while clr_busy=1 is dropped; the bank is unchanged.
- Read: rdata_x <= bank[raddr_x] on each edge (1-cycle latency). Ports A and B are independent; both may address the same register.
- Bypass: if an accepted write hits waddr==raddr_x in the same cycle, rdata_x shows the merged value: new lanes where wmask=1, old lanes elsewhere. A read never returns stale data.
- Clear state machine:
  - IDLE: clr_req=1 -> CLEAR, counter=0, clr_busy=1.
  - CLEAR: bank[counter] <= 0 each cycle, counter increments. After the counter reaches DEPTH-1 -> DONE. Takes DEPTH cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
  - clr_req while CLEAR or DONE is ignored (no restart, no queueing).
  - clr_req held high re-triggers from IDLE on the cycle after DONE.
- Reads during a clear are legal. Registers already cleared read 0; the remaining ones read their old value. A read of the register being cleared this cycle returns 0 (bypass rule applies).
- Without PARITY_EN: par_err_a=par_err_b=0 always; par_flip is ignored.

Optional Feature:
- Macro PARITY_EN.
- When defined:
  - Each lane stores an even-parity bit; the bank is WIDTH+LANES bits wide.
  - A write stores ^lane for each written lane, inverted when par_flip=1.
  - A clear stores data 0 with parity 0.
  - par_err_x registers the OR of per-lane mismatches for the register read; bypassed lanes use the freshly computed parity.
- When undefined: no parity storage or logic; par_err outputs are constant 0.

Test Plan:
- Reset, then read all DEPTH addresses on A and B -> all rdata 0, par_err 0, clr_busy 0.
- Write reg3=0xBEEF with wmask=2'b11, then reg3=0x1234 with wmask=2'b01 -> next-cycle read of reg3 = 0xBE34.
- Same-cycle write reg5=0xA5A5 (wmask=11) with raddr_a=raddr_b=5 -> both rdata = 0xA5A5 one cycle later (bypass).
- Fill all regs, pulse clr_req, attempt write reg0=0xFFFF at cycle 2 -> clr_busy high exactly 8 cycles, clr_done pulses once, write dropped, all regs read 0.
- Start clear, assert rst=0 at cycle 4 -> outputs 0 immediately, no clr_done. After release, a new clr_req runs the full 8 cycles.
- PARITY_EN: write reg2=0x0F0F with par_flip=1, wmask=01 -> read reg2 gives par_err=1. Rewrite with par_flip=0 -> par_err=0.

Source files
------------

// File: rtl/vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : vreg_bank
// Desc     : DEPTH x WIDTH vector register bank: lane-masked write port, two
//            registered read ports with write/clear bypass, and a sequenced
//            clear-all engine. Optional lane parity selected with PARITY_EN.
// Revision : 1.0
// ============================================================================
module vreg_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [LANES-1:0]         wmask,
    output logic                     wr_ready,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    input  logic                     par_flip,
    output logic                     par_err_a,
    output logic                     par_err_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = WIDTH / LANES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             w_clr_en;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_bitmask;
    logic [WIDTH-1:0] w_wmerge;
    logic [WIDTH-1:0] w_nxt_a;
    logic [WIDTH-1:0] w_nxt_b;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_bitmask[gi*LW +: LW] = {LW{wmask[gi]}};
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clr_busy = (r_state == S_CLEAR);
    assign clr_done = (r_state == S_DONE);
    assign wr_ready = !clr_busy;

    assign w_clr_en = clr_busy;
    assign w_wr_en  = we && wr_ready;
    assign w_wmerge = (r_mem[waddr] & ~w_bitmask) | (wdata & w_bitmask);

    // ------------------------------------------------------------------
    // Storage and read ports; reads see this cycle's clear or write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= w_wmerge;
        end
    end

    always_comb begin
        w_nxt_a = r_mem[raddr_a];
        if (w_clr_en && (r_cnt == raddr_a)) begin
            w_nxt_a = '0;
        end else if (w_wr_en && (waddr == raddr_a)) begin
            w_nxt_a = w_wmerge;
        end
    end

    always_comb begin
        w_nxt_b = r_mem[raddr_b];
        if (w_clr_en && (r_cnt == raddr_b)) begin
            w_nxt_b = '0;
        end else if (w_wr_en && (waddr == raddr_b)) begin
            w_nxt_b = w_wmerge;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_rdata_a <= w_nxt_a;
            r_rdata_b <= w_nxt_b;
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;

`ifdef PARITY_EN
    logic [LANES-1:0] r_par [DEPTH];
    logic [LANES-1:0] w_wpar;
    logic [LANES-1:0] w_pmerge;
    logic [LANES-1:0] w_npar_a;
    logic [LANES-1:0] w_npar_b;
    logic [LANES-1:0] w_dpar_a;
    logic [LANES-1:0] w_dpar_b;
    logic             r_perr_a;
    logic             r_perr_b;

    // par_flip deliberately corrupts the stored bit so error paths can be exercised
    for (genvar gi = 0; gi < LANES; gi++) begin : g_par
        assign w_wpar[gi]   = (^wdata[gi*LW +: LW]) ^ par_flip;
        assign w_dpar_a[gi] = ^w_nxt_a[gi*LW +: LW];
        assign w_dpar_b[gi] = ^w_nxt_b[gi*LW +: LW];
    end

    assign w_pmerge = (r_par[waddr] & ~wmask) | (w_wpar & wmask);

    always_comb begin
        w_npar_a = r_par[raddr_a];
        if (w_clr_en && (r_cnt == raddr_a)) begin
            w_npar_a = '0;
        end else if (w_wr_en && (waddr == raddr_a)) begin
            w_npar_a = w_pmerge;
        end
    end

    always_comb begin
        w_npar_b = r_par[raddr_b];
        if (w_clr_en && (r_cnt == raddr_b)) begin
            w_npar_b = '0;
        end else if (w_wr_en && (waddr == raddr_b)) begin
            w_npar_b = w_pmerge;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= '0;
            end
            r_perr_a <= 1'b0;
            r_perr_b <= 1'b0;
        end else begin
            if (w_clr_en) begin
                r_par[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_par[waddr] <= w_pmerge;
            end
            r_perr_a <= |(w_dpar_a ^ w_npar_a);
            r_perr_b <= |(w_dpar_b ^ w_npar_b);
        end
    end

    assign par_err_a = r_perr_a;
    assign par_err_b = r_perr_b;
`else
    logic w_unused_par_flip;
    assign w_unused_par_flip = par_flip;
    assign par_err_a = 1'b0;
    assign par_err_b = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vreg_bank
// Desc     : Self-checking bench for vreg_bank with a behavioural bank model.
// Revision : 1.0
// ============================================================================
module tb_vreg_bank;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int AW    = 3;
    localparam int LW    = WIDTH / LANES;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             we       = 1'b0;
    logic [AW-1:0]    waddr    = '0;
    logic [WIDTH-1:0] wdata    = '0;
    logic [LANES-1:0] wmask    = '0;
    logic [AW-1:0]    raddr_a  = '0;
    logic [AW-1:0]    raddr_b  = '0;
    logic             clr_req  = 1'b0;
    logic             par_flip = 1'b0;
    logic             wr_ready;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             clr_busy;
    logic             clr_done;
    logic             par_err_a;
    logic             par_err_b;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [LANES-1:0] m_par [DEPTH];
    int               m_left;
    bit               m_done;
    logic [WIDTH-1:0] m_ra;
    logic [WIDTH-1:0] m_rb;
    logic             m_pea;
    logic             m_peb;

    vreg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wmask    (wmask),
        .wr_ready (wr_ready),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .par_flip (par_flip),
        .par_err_a(par_err_a),
        .par_err_b(par_err_b)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES-1:0] lane_par(input logic [WIDTH-1:0] d);
        logic [LANES-1:0] p;
        for (int l = 0; l < LANES; l++) p[l] = ^d[l*LW +: LW];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_par[i] = '0;
        end
        m_left = 0;
        m_done = 0;
        m_ra   = '0;
        m_rb   = '0;
        m_pea  = 1'b0;
        m_peb  = 1'b0;
    endtask

    // One clock: apply the spec rules to the model, then the read ports
    // show the post-edge contents of the addressed registers.
    task automatic tick();
        bit acc;
        int idx;
        acc = we && (m_left == 0);
        @(posedge clk);
        if (m_left > 0) begin
            idx        = DEPTH - m_left;
            m_mem[idx] = '0;
            m_par[idx] = '0;
            m_left     = m_left - 1;
            m_done     = (m_left == 0);
        end else if (m_done) begin
            m_done = 0;
        end else if (clr_req) begin
            m_left = DEPTH;
        end
        if (acc) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) begin
                    m_mem[waddr][l*LW +: LW] = wdata[l*LW +: LW];
                    m_par[waddr][l] = (^wdata[l*LW +: LW]) ^ par_flip;
                end
            end
        end
        m_ra  = m_mem[raddr_a];
        m_rb  = m_mem[raddr_b];
        m_pea = |(lane_par(m_mem[raddr_a]) ^ m_par[raddr_a]);
        m_peb = |(lane_par(m_mem[raddr_b]) ^ m_par[raddr_b]);
`ifndef PARITY_EN
        m_pea = 1'b0;
        m_peb = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        checks++; if (rdata_a !== '0) begin errors++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
        checks++; if (rdata_b !== '0) begin errors++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", clr_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        rst = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(DEPTH - 1 - i);
            tick();
            checks++; if (rdata_a !== '0) begin errors++; $display("FAIL reset_read_a[%0d] got=%h exp=0", i, rdata_a); end
            checks++; if (rdata_b !== '0) begin errors++; $display("FAIL reset_read_b[%0d] got=%h exp=0", i, rdata_b); end
            checks++; if (par_err_a !== 1'b0 || par_err_b !== 1'b0) begin
                errors++; $display("FAIL reset_par_err[%0d] got=%b%b exp=00", i, par_err_a, par_err_b);
            end
        end
    endtask

    task automatic test_masked_write();
        we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; wmask = 2'b11;
        tick();
        wdata = 16'h1234; wmask = 2'b01;
        tick();
        we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd3;
        tick();
        checks++; if (rdata_a !== 16'hBE34) begin errors++; $display("FAIL masked_write_a got=%h exp=be34", rdata_a); end
        checks++; if (rdata_b !== 16'hBE34) begin errors++; $display("FAIL masked_write_b got=%h exp=be34", rdata_b); end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 3'd5; wdata = 16'hA5A5; wmask = 2'b11;
        raddr_a = 3'd5; raddr_b = 3'd5;
        tick();
        we = 1'b0;
        checks++; if (rdata_a !== 16'hA5A5) begin errors++; $display("FAIL bypass_a got=%h exp=a5a5", rdata_a); end
        checks++; if (rdata_b !== 16'hA5A5) begin errors++; $display("FAIL bypass_b got=%h exp=a5a5", rdata_b); end
    endtask

    task automatic test_parity();
        logic exp_pe;
`ifdef PARITY_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        we = 1'b1; waddr = 3'd2; wdata = 16'h0F0F; wmask = 2'b11; par_flip = 1'b0;
        tick();
        wmask = 2'b01; par_flip = 1'b1;
        tick();
        we = 1'b0; par_flip = 1'b0; raddr_a = 3'd2; raddr_b = 3'd2;
        tick();
        checks++; if (rdata_a !== 16'h0F0F) begin errors++; $display("FAIL parity_data got=%h exp=0f0f", rdata_a); end
        checks++; if (par_err_a !== exp_pe) begin errors++; $display("FAIL parity_flip_a got=%b exp=%b", par_err_a, exp_pe); end
        checks++; if (par_err_b !== exp_pe) begin errors++; $display("FAIL parity_flip_b got=%b exp=%b", par_err_b, exp_pe); end
        we = 1'b1; wmask = 2'b01; par_flip = 1'b0;
        tick();
        we = 1'b0;
        tick();
        checks++; if (par_err_a !== 1'b0) begin errors++; $display("FAIL parity_clean_a got=%b exp=0", par_err_a); end
        checks++; if (par_err_b !== 1'b0) begin errors++; $display("FAIL parity_clean_b got=%b exp=0", par_err_b); end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = WIDTH'($urandom) | 16'h0100; wmask = 2'b11;
            tick();
        end
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; wmask = 2'b11;
                checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_wr_ready got=%b exp=0", wr_ready); end
            end else begin
                we = 1'b0;
            end
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        we = 1'b0;
        checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", busy_cnt, DEPTH); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clear_done_pulses got=%0d exp=1", done_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = AW'(i); raddr_b = AW'(i);
            tick();
            checks++; if (rdata_a !== '0) begin errors++; $display("FAIL clear_read_a[%0d] got=%h exp=0", i, rdata_a); end
            checks++; if (rdata_b !== '0) begin errors++; $display("FAIL clear_read_b[%0d] got=%h exp=0", i, rdata_b); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt;
        int done_cnt;
        we = 1'b1; waddr = 3'd7; wdata = 16'hFFFF; wmask = 2'b11;
        tick();
        we = 1'b0; raddr_a = 3'd7; raddr_b = 3'd7; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (rdata_a !== '0) begin errors++; $display("FAIL midrst_rdata_a got=%h exp=0", rdata_a); end
        checks++; if (rdata_b !== '0) begin errors++; $display("FAIL midrst_rdata_b got=%h exp=0", rdata_b); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", clr_busy); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", clr_done); end
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (clr_done) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_stray_done got=%0d exp=0", done_cnt); end
        checks++; if (rdata_a !== '0) begin errors++; $display("FAIL midrst_reg7 got=%h exp=0", rdata_a); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            tick();
        end
        checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL midrst_rerun_busy got=%0d exp=%0d", busy_cnt, DEPTH); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_rerun_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we       = ($urandom_range(0, 3) != 0);
            waddr    = AW'($urandom_range(0, DEPTH - 1));
            wdata    = WIDTH'($urandom);
            wmask    = LANES'($urandom_range(0, 3));
            raddr_a  = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            raddr_b  = AW'($urandom_range(0, DEPTH - 1));
            clr_req  = ($urandom_range(0, 24) == 0);
            par_flip = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (rdata_a !== m_ra) begin errors++; $display("FAIL rand_rdata_a n=%0d got=%h exp=%h", n, rdata_a, m_ra); end
            checks++; if (rdata_b !== m_rb) begin errors++; $display("FAIL rand_rdata_b n=%0d got=%h exp=%h", n, rdata_b, m_rb); end
            checks++; if (par_err_a !== m_pea) begin errors++; $display("FAIL rand_par_err_a n=%0d got=%b exp=%b", n, par_err_a, m_pea); end
            checks++; if (par_err_b !== m_peb) begin errors++; $display("FAIL rand_par_err_b n=%0d got=%b exp=%b", n, par_err_b, m_peb); end
            checks++; if (clr_busy !== (m_left > 0)) begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, clr_busy, (m_left > 0)); end
            checks++; if (clr_done !== m_done) begin errors++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, clr_done, m_done); end
            checks++; if (wr_ready !== (m_left == 0)) begin errors++; $display("FAIL rand_wr_ready n=%0d got=%b exp=%b", n, wr_ready, (m_left == 0)); end
        end
        we = 1'b0; clr_req = 1'b0; par_flip = 1'b0;
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_bypass();
        test_parity();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
